// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
// Purpose : bundles every non-clock signal of the ID/EX operand stage.
//   master : the surrounding pipeline. It drives the decoded ID fields, the
//            stall/flush controls and the EX/MEM and MEM/WB writeback taps.
//   slave  : the ID/EX operand stage. It drives the ALU operands, the
//            registered EX fields, the forwarding selects and the hazard
//            outputs.
// Signals (W = datapath width, RIDX = register index width):
//   id_*        decoded instruction from ID (values, indices, opcode, flags)
//   stall_in    downstream hold; flush: turn the EX register into a bubble
//   exm_*/mwb_* destination, write enable and result of the EX/MEM and MEM/WB
//               stages, used for forwarding
//   alu_*       ALU Rs/Rt operands and opcode
//   ex_*        registered valid, destination, write enable and load flag
//   fwd_*_sel   00 regfile, 01 EX/MEM, 10 MEM/WB
//   hazard_stall, stall_count  load-use stall flag and saturating count
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
  parameter int W     = 16,
  parameter int RIDX  = 3,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [W-1:0]    id_rs_val;
  logic [W-1:0]    id_rt_val;
  logic [W-1:0]    id_imm;
  logic            id_use_imm;
  logic [RIDX-1:0] id_rs_idx;
  logic [RIDX-1:0] id_rt_idx;
  logic [RIDX-1:0] id_rd_idx;
  logic [2:0]      id_alu_op;
  logic            id_reg_wr;
  logic            id_mem_rd;
  logic            stall_in;
  logic            flush;
  logic            exm_reg_wr;
  logic [RIDX-1:0] exm_rd_idx;
  logic [W-1:0]    exm_result;
  logic            mwb_reg_wr;
  logic [RIDX-1:0] mwb_rd_idx;
  logic [W-1:0]    mwb_result;
  logic [W-1:0]    alu_rs;
  logic [W-1:0]    alu_rt;
  logic [2:0]      alu_op;
  logic            ex_valid;
  logic [RIDX-1:0] ex_rd_idx;
  logic            ex_reg_wr;
  logic            ex_mem_rd;
  logic [1:0]      fwd_rs_sel;
  logic [1:0]      fwd_rt_sel;
  logic            hazard_stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs_val, id_rt_val, id_imm, id_use_imm,
           id_rs_idx, id_rt_idx, id_rd_idx, id_alu_op, id_reg_wr, id_mem_rd,
           stall_in, flush, exm_reg_wr, exm_rd_idx, exm_result,
           mwb_reg_wr, mwb_rd_idx, mwb_result,
    input  alu_rs, alu_rt, alu_op, ex_valid, ex_rd_idx, ex_reg_wr, ex_mem_rd,
           fwd_rs_sel, fwd_rt_sel, hazard_stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs_val, id_rt_val, id_imm, id_use_imm,
           id_rs_idx, id_rt_idx, id_rd_idx, id_alu_op, id_reg_wr, id_mem_rd,
           stall_in, flush, exm_reg_wr, exm_rd_idx, exm_result,
           mwb_reg_wr, mwb_rd_idx, mwb_result,
    output alu_rs, alu_rt, alu_op, ex_valid, ex_rd_idx, ex_reg_wr, ex_mem_rd,
           fwd_rs_sel, fwd_rt_sel, hazard_stall, stall_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// Purpose : ID/EX pipeline register in front of the 16-bit ALU. It latches
//   the decoded operands, opcode and destination from ID, forwards results
//   from EX/MEM and MEM/WB, picks the immediate for Rt, detects load-use
//   hazards (bubble insertion plus a saturating stall counter).
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   pipe_io  id_ex_operand_stage_if.slave (all data/control signals)
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int W     = 16,
  parameter int RIDX  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  id_ex_operand_stage_if.slave  pipe_io
);

  logic            valid_q,  valid_d;
  logic [W-1:0]    rsVal_q,  rsVal_d;
  logic [W-1:0]    rtVal_q,  rtVal_d;
  logic [W-1:0]    imm_q,    imm_d;
  logic            useImm_q, useImm_d;
  logic [RIDX-1:0] rsIdx_q,  rsIdx_d;
  logic [RIDX-1:0] rtIdx_q,  rtIdx_d;
  logic [RIDX-1:0] rdIdx_q,  rdIdx_d;
  logic [2:0]      aluOp_q,  aluOp_d;
  logic            regWr_q,  regWr_d;
  logic            memRd_q,  memRd_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic            hazard;
  logic [W-1:0]    rsOperand, rtOperand;
  logic [1:0]      rsSel, rtSel;

  // Load-use: the load in EX produces its data too late for the instruction
  // in ID. With an immediate, the Rt index is not a real source.
  assign hazard = valid_q && memRd_q && regWr_q && (rdIdx_q != '0) &&
                  pipe_io.id_valid &&
                  ((rdIdx_q == pipe_io.id_rs_idx) ||
                   (!pipe_io.id_use_imm && (rdIdx_q == pipe_io.id_rt_idx)));

  // EX register next state. Priority: flush > stall_in > hazard > load.
  // Bubbles only clear valid; the stale fields are masked at the outputs.
  always_comb begin
    valid_d  = valid_q;
    rsVal_d  = rsVal_q;
    rtVal_d  = rtVal_q;
    imm_d    = imm_q;
    useImm_d = useImm_q;
    rsIdx_d  = rsIdx_q;
    rtIdx_d  = rtIdx_q;
    rdIdx_d  = rdIdx_q;
    aluOp_d  = aluOp_q;
    regWr_d  = regWr_q;
    memRd_d  = memRd_q;
    if (pipe_io.flush) begin
      valid_d = 1'b0;
    end else if (pipe_io.stall_in) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
    end else begin
      valid_d  = pipe_io.id_valid;
      rsVal_d  = pipe_io.id_rs_val;
      rtVal_d  = pipe_io.id_rt_val;
      imm_d    = pipe_io.id_imm;
      useImm_d = pipe_io.id_use_imm;
      rsIdx_d  = pipe_io.id_rs_idx;
      rtIdx_d  = pipe_io.id_rt_idx;
      rdIdx_d  = pipe_io.id_rd_idx;
      aluOp_d  = pipe_io.id_alu_op;
      regWr_d  = pipe_io.id_reg_wr;
      memRd_d  = pipe_io.id_mem_rd;
    end
  end

  // Saturating stall counter; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      rsVal_q  <= '0;
      rtVal_q  <= '0;
      imm_q    <= '0;
      useImm_q <= 1'b0;
      rsIdx_q  <= '0;
      rtIdx_q  <= '0;
      rdIdx_q  <= '0;
      aluOp_q  <= '0;
      regWr_q  <= 1'b0;
      memRd_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      rsVal_q  <= rsVal_d;
      rtVal_q  <= rtVal_d;
      imm_q    <= imm_d;
      useImm_q <= useImm_d;
      rsIdx_q  <= rsIdx_d;
      rtIdx_q  <= rtIdx_d;
      rdIdx_q  <= rdIdx_d;
      aluOp_q  <= aluOp_d;
      regWr_q  <= regWr_d;
      memRd_q  <= memRd_d;
      cnt_q    <= cnt_d;
    end
  end

  // Forwarding from the registered indices. R0 is hard zero and never
  // forwarded; EX/MEM is newer than MEM/WB so it wins.
  always_comb begin
    rsSel     = 2'b00;
    rsOperand = rsVal_q;
    if (rsIdx_q == '0) begin
      rsOperand = '0;
    end else if (pipe_io.exm_reg_wr && (pipe_io.exm_rd_idx == rsIdx_q)) begin
      rsSel     = 2'b01;
      rsOperand = pipe_io.exm_result;
    end else if (pipe_io.mwb_reg_wr && (pipe_io.mwb_rd_idx == rsIdx_q)) begin
      rsSel     = 2'b10;
      rsOperand = pipe_io.mwb_result;
    end

    rtSel     = 2'b00;
    rtOperand = rtVal_q;
    if (useImm_q) begin
      rtOperand = imm_q;
    end else if (rtIdx_q == '0) begin
      rtOperand = '0;
    end else if (pipe_io.exm_reg_wr && (pipe_io.exm_rd_idx == rtIdx_q)) begin
      rtSel     = 2'b01;
      rtOperand = pipe_io.exm_result;
    end else if (pipe_io.mwb_reg_wr && (pipe_io.mwb_rd_idx == rtIdx_q)) begin
      rtSel     = 2'b10;
      rtOperand = pipe_io.mwb_result;
    end
  end

  // A bubble presents neutral values to the ALU and downstream stages.
  assign pipe_io.alu_rs       = valid_q ? rsOperand : '0;
  assign pipe_io.alu_rt       = valid_q ? rtOperand : '0;
  assign pipe_io.alu_op       = valid_q ? aluOp_q : 3'b111;
  assign pipe_io.fwd_rs_sel   = valid_q ? rsSel : 2'b00;
  assign pipe_io.fwd_rt_sel   = valid_q ? rtSel : 2'b00;
  assign pipe_io.ex_valid     = valid_q;
  assign pipe_io.ex_rd_idx    = rdIdx_q;
  assign pipe_io.ex_reg_wr    = valid_q & regWr_q;
  assign pipe_io.ex_mem_rd    = valid_q & memRd_q;
  assign pipe_io.hazard_stall = hazard;
  assign pipe_io.stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
// Directed vectors for the ID/EX operand stage: a table of one-cycle
// records followed by hand-written load-use, saturation and async reset
// sequences.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

  typedef struct {
    logic        idValid;
    logic [15:0] rsVal;
    logic [15:0] rtVal;
    logic [15:0] imm;
    logic        useImm;
    logic [2:0]  rsIdx;
    logic [2:0]  rtIdx;
    logic [2:0]  rdIdx;
    logic [2:0]  op;
    logic        regWr;
    logic        memRd;
    logic        stallIn;
    logic        flush;
    logic        exmWr;
    logic [2:0]  exmRd;
    logic [15:0] exmRes;
    logic        mwbWr;
    logic [2:0]  mwbRd;
    logic [15:0] mwbRes;
    logic [15:0] eRs;
    logic [15:0] eRt;
    logic [2:0]  eOp;
    logic        eValid;
    logic [1:0]  eFwdRs;
    logic [1:0]  eFwdRt;
    logic        eRegWr;
    logic        eMemRd;
    logic        eHaz;
    logic [15:0] eCnt;
  } vec_t;

  logic clk;
  logic reset;
  int   numVectors;
  int   numMiscompares;
  vec_t vecs [12];

  id_ex_operand_stage_if #(.W(16), .RIDX(3), .CNT_W(16)) pipe ();

  id_ex_operand_stage #(.W(16), .RIDX(3), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .pipe_io (pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numVectors++;
    if (act !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveId(input vec_t v);
    pipe.id_valid   = v.idValid;
    pipe.id_rs_val  = v.rsVal;
    pipe.id_rt_val  = v.rtVal;
    pipe.id_imm     = v.imm;
    pipe.id_use_imm = v.useImm;
    pipe.id_rs_idx  = v.rsIdx;
    pipe.id_rt_idx  = v.rtIdx;
    pipe.id_rd_idx  = v.rdIdx;
    pipe.id_alu_op  = v.op;
    pipe.id_reg_wr  = v.regWr;
    pipe.id_mem_rd  = v.memRd;
    pipe.stall_in   = v.stallIn;
    pipe.flush      = v.flush;
    pipe.exm_reg_wr = v.exmWr;
    pipe.exm_rd_idx = v.exmRd;
    pipe.exm_result = v.exmRes;
    pipe.mwb_reg_wr = v.mwbWr;
    pipe.mwb_rd_idx = v.mwbRd;
    pipe.mwb_result = v.mwbRes;
  endtask

  // Drive a record on the falling edge, then sample #1 after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveId(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d alu_rs", i), 32'(pipe.alu_rs), 32'(v.eRs));
    checkOutput($sformatf("v%0d alu_rt", i), 32'(pipe.alu_rt), 32'(v.eRt));
    checkOutput($sformatf("v%0d alu_op", i), 32'(pipe.alu_op), 32'(v.eOp));
    checkOutput($sformatf("v%0d ex_valid", i), 32'(pipe.ex_valid), 32'(v.eValid));
    checkOutput($sformatf("v%0d fwd_rs_sel", i), 32'(pipe.fwd_rs_sel), 32'(v.eFwdRs));
    checkOutput($sformatf("v%0d fwd_rt_sel", i), 32'(pipe.fwd_rt_sel), 32'(v.eFwdRt));
    checkOutput($sformatf("v%0d ex_reg_wr", i), 32'(pipe.ex_reg_wr), 32'(v.eRegWr));
    checkOutput($sformatf("v%0d ex_mem_rd", i), 32'(pipe.ex_mem_rd), 32'(v.eMemRd));
    checkOutput($sformatf("v%0d hazard_stall", i), 32'(pipe.hazard_stall), 32'(v.eHaz));
    checkOutput($sformatf("v%0d stall_count", i), 32'(pipe.stall_count), 32'(v.eCnt));
  endtask

  initial begin
    vec_t v;
    numVectors     = 0;
    numMiscompares = 0;

    // idValid,rsVal,rtVal,imm,useImm,rsIdx,rtIdx,rdIdx,op,regWr,memRd,stallIn,flush,
    // exmWr,exmRd,exmRes, mwbWr,mwbRd,mwbRes,
    // eRs,eRt,eOp,eValid,eFwdRs,eFwdRt,eRegWr,eMemRd,eHaz,eCnt
    vecs[0]  = '{1'b1, 16'h0005, 16'h0003, 16'h0000, 1'b0, 3'd1, 3'd2, 3'd4, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                 16'h0005, 16'h0003, 3'b001, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 16'h1111, 16'h2222, 16'h0000, 1'b0, 3'd1, 3'd2, 3'd5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 3'd1, 16'h00AA, 1'b1, 3'd1, 16'h0055,
                 16'h00AA, 16'h2222, 3'b010, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 16'h0303, 16'h0202, 16'h0000, 1'b0, 3'd3, 3'd2, 3'd6, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 3'd3, 16'hBEEF, 1'b1, 3'd2, 16'h0055,
                 16'h0303, 16'h0055, 3'b000, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 16'h1234, 16'h7777, 16'h0004, 1'b1, 3'd0, 3'd5, 3'd1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd5, 16'h9999,
                 16'h0000, 16'h0004, 3'b001, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 16'h0010, 16'h0000, 16'h0008, 1'b1, 3'd1, 3'd0, 3'd3, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                 16'h0010, 16'h0008, 3'b001, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 16'h0030, 16'h0002, 16'h0000, 1'b0, 3'd3, 3'd2, 3'd4, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                 16'h0000, 16'h0000, 3'b111, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 16'h0030, 16'h0002, 16'h0000, 1'b0, 3'd3, 3'd2, 3'd4, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 3'd3, 16'h00C0, 1'b0, 3'd0, 16'h0000,
                 16'h00C0, 16'h0002, 3'b010, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 16'h0001, 16'h0006, 16'h0000, 1'b0, 3'd2, 3'd6, 3'd7, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 3'd6, 16'h0A0A, 1'b1, 3'd6, 16'h0B0B,
                 16'h0001, 16'h0A0A, 3'b011, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{1'b0, 16'h5555, 16'h0000, 16'h0000, 1'b0, 3'd1, 3'd0, 3'd2, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 16'h0000,
                 16'h0000, 16'h0000, 3'b111, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 16'hF000, 16'h0000, 16'h0004, 1'b1, 3'd7, 3'd0, 3'd2, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 3'd7, 16'h1111, 1'b1, 3'd7, 16'h8000,
                 16'h8000, 16'h0004, 3'b100, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 16'h9999, 16'h0000, 16'h0000, 1'b0, 3'd1, 3'd0, 3'd5, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b0, 3'd7, 16'h1111, 1'b1, 3'd7, 16'h8000,
                 16'h8000, 16'h0004, 3'b100, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[11] = '{1'b1, 16'h9999, 16'h0000, 16'h0000, 1'b0, 3'd1, 3'd0, 3'd5, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 3'd7, 16'h1111, 1'b1, 3'd7, 16'h8000,
                 16'h0000, 16'h0000, 3'b111, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};

    // Reset state
    v = vecs[0];
    v.idValid = 1'b0;
    driveId(v);
    reset = 1'b1;
    #2;
    checkOutput("reset alu_rs", 32'(pipe.alu_rs), 32'h0);
    checkOutput("reset alu_rt", 32'(pipe.alu_rt), 32'h0);
    checkOutput("reset alu_op", 32'(pipe.alu_op), 32'h7);
    checkOutput("reset ex_valid", 32'(pipe.ex_valid), 32'h0);
    checkOutput("reset stall_count", 32'(pipe.stall_count), 32'h0);
    checkOutput("reset hazard_stall", 32'(pipe.hazard_stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Load-use: load R3 into EX, then probe the hazard combinationally
    v = vecs[4];
    applyStimulus(v);
    checkOutput("lu load ex_mem_rd", 32'(pipe.ex_mem_rd), 32'h1);
    @(negedge clk);
    v = vecs[5];
    v.rsIdx = 3'd1;
    v.rtIdx = 3'd3;
    v.useImm = 1'b1;
    driveId(v);
    #1;
    checkOutput("lu rt-with-imm hazard", 32'(pipe.hazard_stall), 32'h0);
    v.useImm = 1'b0;
    driveId(v);
    #1;
    checkOutput("lu rt hazard", 32'(pipe.hazard_stall), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("lu bubble ex_valid", 32'(pipe.ex_valid), 32'h0);
    checkOutput("lu bubble alu_op", 32'(pipe.alu_op), 32'h7);
    checkOutput("lu count", 32'(pipe.stall_count), 32'd2);
    checkOutput("lu hazard drops", 32'(pipe.hazard_stall), 32'h0);

    // Saturation: hold the load in EX with stall_in so the hazard persists
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("sat pre count cleared", 32'(pipe.stall_count), 32'h0);
    reset = 1'b0;
    applyStimulus(vecs[4]);
    @(negedge clk);
    v = vecs[5];
    v.stallIn = 1'b1;
    driveId(v);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat count 0xFFFE", 32'(pipe.stall_count), 32'hFFFE);
    @(posedge clk);
    #1;
    checkOutput("sat count 0xFFFF", 32'(pipe.stall_count), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat count held", 32'(pipe.stall_count), 32'hFFFF);
    checkOutput("sat hazard", 32'(pipe.hazard_stall), 32'h1);
    checkOutput("sat held alu_op", 32'(pipe.alu_op), 32'h1);
    checkOutput("sat held alu_rs", 32'(pipe.alu_rs), 32'h0010);

    // Asynchronous reset in the middle of the stall, away from any edge
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async ex_valid", 32'(pipe.ex_valid), 32'h0);
    checkOutput("async alu_op", 32'(pipe.alu_op), 32'h7);
    checkOutput("async alu_rs", 32'(pipe.alu_rs), 32'h0);
    checkOutput("async hazard", 32'(pipe.hazard_stall), 32'h0);
    checkOutput("async count", 32'(pipe.stall_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
